alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Round-robin arbiter and sequencer that shares the 4-bit ALU datapath (select/in_c/in_x/in_y -> out_s/out_c/zero/overflow) between two requesters. It accepts 8-bit operation requests over a valid/ready handshake and executes each as one 4-bit ALU pass (narrow) or two chained passes (wide). It then returns the result and flags on a backpressured response channel. It sits between the requesting units and the combinational ALU instance.

## Interface
- No parameters; widths are fixed by the ALU (4-bit slice, 8-bit operand).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept strobe, one-hot or zero
- req_op0, req_op1  in  3 each  ALU op: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less-than, 111 equal
- req_wide  in  2  per-requester 8-bit mode flag
- req_a0, req_b0, req_a1, req_b1  in  8 each  operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_result  out  8  result
- rsp_carry, rsp_zero, rsp_overflow  out  1 each  flags
- alu_select  out  3  to ALU select
- alu_in_c  out  1  to ALU carry-in
- alu_in_x, alu_in_y  out  4 each  to ALU operands
- alu_out_s  in  4  from ALU result
- alu_out_c, alu_zero, alu_overflow  in  1 each  from ALU flags (combinational, same cycle)

## Operation
- States: IDLE, LO, HI, RESP.
- **IDLE**
  - Arbitrate among asserted req_valid bits; round-robin, the requester not granted last wins on contention.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - req_ready[g] = 1 combinationally for the winner only.
  - On that edge, latch op, wide, a, b and id; next state LO.
- **Wide eligibility**: effective wide = req_wide & (op <= 101). For ops 110/111 the wide flag is ignored.
- **LO** (low nibble pass)
  - Narrow: alu_select = op, alu_in_x = a[3:0], alu_in_y = b[3:0], alu_in_c = (op == 001).
  - Wide add: select 000, in_c 0, y = b[3:0].
  - Wide sub: select 000, in_c 1, y = ~b[3:0].
  - Wide 010–101: select = op, in_c 0.
  - Capture out_s into res[3:0], and carry, zero and overflow into internal regs.
  - Next state: HI if wide, else RESP.
- **HI** (high nibble pass)
  - x = a[7:4]; y = b[7:4], or ~b[7:4] for sub.
  - For add/sub: select 000, in_c = captured LO carry.
  - For 010–101: select = op, in_c 0.
  - Capture res[7:4], carry and overflow from this pass.
  - zero = LO zero & alu_zero.
  - Next state RESP.
- **Narrow result**: res[7:4] = 0; flags are taken from the LO pass.
- **Outside LO/HI**: alu_select, alu_in_c, alu_in_x and alu_in_y are driven to 0.
- **RESP**
  - rsp_valid = 1; rsp_* come from registers and stay stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: update last_grant = id, go to IDLE.
  - req_ready = 0 throughout RESP.
- **Sub flag convention**: carry = 1 means no borrow (A + ~B + 1).

## Timing
- **Reset values**: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, all rsp flags 0, all alu_* outputs 0, last_grant 1.
- **Latency** (accept edge = cycle 0):
  - Narrow: LO in cycle 1, rsp_valid from cycle 2.
  - Wide: LO in cycle 1, HI in cycle 2, rsp_valid from cycle 3.
- **Throughput**: minimum 3 cycles per narrow op and 4 per wide, since the next request is accepted only in IDLE after the handshake.
- **Simultaneous events**
  - A request arriving while busy waits; req_valid must be held by the requester.
  - Contention is resolved at the IDLE cycle only.
- **Reset mid-operation**: asynchronous reset in LO, HI or RESP discards the operation. No response is issued and all outputs return to reset values immediately.

## Test plan
- **Narrow add**: r0 op 000, a 0x07, b 0x01, wide 0.
  - Response 2 cycles after accept: result 0x08, carry 0, zero 0, overflow 1, id 0.
- **Wide add**: r1 op 000, a 0x9C, b 0x75, wide 1.
  - LO carry 1 chained into HI.
  - Response 3 cycles after accept: result 0x11, carry 1, zero 0, overflow 0, id 1.
- **Wide sub**: r0 op 001, a 0x20, b 0x21, wide 1.
  - alu_in_y = 0xE in LO, alu_in_c = 1 in LO.
  - Result 0xFF, carry 0 (borrow), zero 0, overflow 0.
- **Contention after reset**: both req_valid = 1 in the same cycle.
  - Requester 0 granted first; requester 1 granted in the next IDLE.
  - With both still valid, requester 0 is granted third (alternation).
- **Backpressure**: rsp_ready held 0 for 5 cycles during a response.
  - rsp_valid and rsp_* stay stable, req_ready stays 0.
  - Handshake occurs on the first cycle with rsp_ready = 1; IDLE follows.
- **Reset in HI**: assert rst during the HI cycle of a wide op.
  - All outputs return to 0 that cycle; no rsp_valid after reset release.
  - The next request is granted to requester 0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational 4-bit ALU slice between two requesters. Each accepted
// 8-bit request runs as one ALU pass (narrow) or as two chained passes (wide:
// low nibble, then high nibble). The result and flags are then held on a
// backpressured response channel.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid[1:0]           per-requester request valid (held until accepted)
//   req_ready[1:0]           accept strobe for the arbitration winner (IDLE only)
//   req_op0/1[2:0]           ALU opcode per requester
//   req_wide[1:0]            per-requester 8-bit mode request
//   req_a0/b0/a1/b1[7:0]     operands per requester
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester index of the response
//   rsp_result[7:0]          result (upper nibble 0 for narrow ops)
//   rsp_carry/zero/overflow  result flags
//   alu_select/in_c/in_x/in_y  drive to the ALU slice (0 outside LO/HI)
//   alu_out_s/out_c/zero/overflow  ALU results, same cycle
// -----------------------------------------------------------------------------
module alu_share_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [2:0] req_op0,
    input  logic [2:0] req_op1,
    input  logic [1:0] req_wide,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_overflow,
    output logic [2:0] alu_select,
    output logic       alu_in_c,
    output logic [3:0] alu_in_x,
    output logic [3:0] alu_in_y,
    input  logic [3:0] alu_out_s,
    input  logic       alu_out_c,
    input  logic       alu_zero,
    input  logic       alu_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD       = 3'b000;
    localparam logic [2:0] OP_SUB       = 3'b001;
    localparam logic [2:0] OP_LAST_WIDE = 3'b101;

    // Compare ops (110/111) produce a single-bit answer, so they never chain.
    function automatic logic wide_eff(input logic [2:0] op, input logic wide);
        return wide & (op <= OP_LAST_WIDE);
    endfunction

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  op_q, op_d;
    logic        wide_q, wide_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        id_q, id_d;
    logic [7:0]  res_q, res_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;

    logic        grant_any_s;
    logic        grant_idx_s;
    logic        is_addsub_s;

    // Round-robin winner: on contention the requester not served last wins.
    always_comb begin
        grant_any_s = req_valid[0] | req_valid[1];
        if (req_valid == 2'b11) begin
            grant_idx_s = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant_idx_s = 1'b1;
        end else begin
            grant_idx_s = 1'b0;
        end
    end

    assign is_addsub_s = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Next-state, operand latching, ALU drive and accept strobe.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        wide_d       = wide_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        res_d        = res_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        req_ready    = 2'b00;
        alu_select   = 3'b000;
        alu_in_c     = 1'b0;
        alu_in_x     = 4'h0;
        alu_in_y     = 4'h0;

        case (state_q)
            ST_IDLE: begin
                // Gate with rst so the strobe is quiet while reset is held.
                if (grant_any_s && !rst) begin
                    req_ready = grant_idx_s ? 2'b10 : 2'b01;
                    id_d      = grant_idx_s;
                    op_d      = grant_idx_s ? req_op1 : req_op0;
                    wide_d    = grant_idx_s ? wide_eff(req_op1, req_wide[1])
                                            : wide_eff(req_op0, req_wide[0]);
                    a_d       = grant_idx_s ? req_a1 : req_a0;
                    b_d       = grant_idx_s ? req_b1 : req_b0;
                    state_d   = ST_LO;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_LO: begin
                alu_in_x = a_q[3:0];
                if (wide_q && (op_q == OP_ADD)) begin
                    alu_select = OP_ADD;
                    alu_in_c   = 1'b0;
                    alu_in_y   = b_q[3:0];
                end else if (wide_q && (op_q == OP_SUB)) begin
                    // Wide subtract is A + ~B + 1 through the adder so the
                    // carry can chain into the high pass.
                    alu_select = OP_ADD;
                    alu_in_c   = 1'b1;
                    alu_in_y   = ~b_q[3:0];
                end else if (wide_q) begin
                    alu_select = op_q;
                    alu_in_c   = 1'b0;
                    alu_in_y   = b_q[3:0];
                end else begin
                    alu_select = op_q;
                    alu_in_c   = (op_q == OP_SUB);
                    alu_in_y   = b_q[3:0];
                end
                res_d   = {4'h0, alu_out_s};
                carry_d = alu_out_c;
                zero_d  = alu_zero;
                ovf_d   = alu_overflow;
                state_d = wide_q ? ST_HI : ST_RESP;
            end

            ST_HI: begin
                alu_in_x = a_q[7:4];
                alu_in_y = (op_q == OP_SUB) ? ~b_q[7:4] : b_q[7:4];
                if (is_addsub_s) begin
                    alu_select = OP_ADD;
                    alu_in_c   = carry_q;
                end else begin
                    alu_select = op_q;
                    alu_in_c   = 1'b0;
                end
                res_d   = {alu_out_s, res_q[3:0]};
                carry_d = alu_out_c;
                ovf_d   = alu_overflow;
                zero_d  = zero_q & alu_zero;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 3'b000;
            wide_q       <= 1'b0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            id_q         <= 1'b0;
            res_q        <= 8'h00;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            wide_q       <= wide_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_carry    = carry_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for alu_share_ctrl. Models the 4-bit ALU slice, drives two requesters
// and a response consumer, and predicts grants, latency and 8-bit results from
// whole-operand arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, req_wide;
    logic [2:0] req_op0, req_op1;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_zero, rsp_overflow;
    logic [2:0] alu_select;
    logic       alu_in_c;
    logic [3:0] alu_in_x, alu_in_y, alu_out_s;
    logic       alu_out_c, alu_zero, alu_overflow;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_wide(req_wide),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow),
        .alu_select(alu_select), .alu_in_c(alu_in_c),
        .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
        .alu_out_s(alu_out_s), .alu_out_c(alu_out_c),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // 4-bit ALU slice: returns {carry, zero, overflow, sum[3:0]}.
    function automatic logic [6:0] alu4(input logic [2:0] sel, input logic [3:0] x,
                                        input logic [3:0] y, input logic cin);
        logic [4:0] t;
        logic [3:0] s;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        t = 5'd0;
        case (sel)
            3'b000: begin
                t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
                s = t[3:0];
                c = t[4];
                v = (x[3] == y[3]) && (s[3] != x[3]);
            end
            3'b001: begin
                t = {1'b0, x} + {1'b0, ~y} + {4'b0000, cin};
                s = t[3:0];
                c = t[4];
                v = (x[3] != y[3]) && (s[3] != x[3]);
            end
            3'b010: s = ~x;
            3'b011: s = x & y;
            3'b100: s = x | y;
            3'b101: s = x ^ y;
            3'b110: s = {3'b000, x < y};
            default: s = {3'b000, x == y};
        endcase
        return {c, (s == 4'h0), v, s};
    endfunction

    always_comb begin
        {alu_out_c, alu_zero, alu_overflow, alu_out_s} = alu4(alu_select, alu_in_x, alu_in_y, alu_in_c);
    end

    // Expected response {carry, zero, overflow, result[7:0]} from 8-bit arithmetic.
    function automatic logic [10:0] ref_rsp(input logic [2:0] op, input logic wide,
                                            input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s9;
        logic [7:0] res;
        logic [6:0] n;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        if (!(wide && op <= 3'd5)) begin
            n = alu4(op, a[3:0], b[3:0], op == 3'b001);
            return {n[6], n[5], n[4], 4'h0, n[3:0]};
        end
        case (op)
            3'd0: begin
                s9 = {1'b0, a} + {1'b0, b};
                res = s9[7:0];
                c = s9[8];
                v = (a[7] == b[7]) && (res[7] != a[7]);
            end
            3'd1: begin
                s9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
                res = s9[7:0];
                c = s9[8];
                v = (a[7] != b[7]) && (res[7] != a[7]);
            end
            3'd2: res = ~a;
            3'd3: res = a & b;
            3'd4: res = a | b;
            default: res = a ^ b;
        endcase
        return {c, (res == 8'h00), v, res};
    endfunction

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester and consumer model state.
    bit         rq_pend [2];
    logic [2:0] rq_op   [2];
    logic       rq_wide [2];
    logic [7:0] rq_a    [2];
    logic [7:0] rq_b    [2];
    logic       rsp_rdy_drv;
    bit         busy;
    int         last_id;
    int         cur_id;
    logic [10:0] cur_exp;
    logic [7:0] cur_a;
    int         resp_at, lo_cyc;
    bit         chk_sub_lo;
    bit         seen_v;
    int         grant_log[$];

    task automatic set_req(input int i, input logic [2:0] op, input logic wide,
                           input logic [7:0] a, input logic [7:0] b);
        rq_pend[i] = 1'b1;
        rq_op[i]   = op;
        rq_wide[i] = wide;
        rq_a[i]    = a;
        rq_b[i]    = b;
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step();
        logic [1:0] exp_rdy;
        bit         exp_v;
        int         w;
        int         lat;
        w = 0;
        req_valid = {rq_pend[1], rq_pend[0]};
        req_op0 = rq_op[0];  req_op1 = rq_op[1];
        req_wide = {rq_wide[1], rq_wide[0]};
        req_a0 = rq_a[0];  req_b0 = rq_b[0];
        req_a1 = rq_a[1];  req_b1 = rq_b[1];
        rsp_ready = rsp_rdy_drv;
        #1;
        exp_rdy = 2'b00;
        if (!busy && (rq_pend[0] || rq_pend[1])) begin
            if (rq_pend[0] && rq_pend[1]) w = (last_id == 0) ? 1 : 0;
            else w = rq_pend[1] ? 1 : 0;
            exp_rdy = (w == 1) ? 2'b10 : 2'b01;
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00 && req_ready != 2'b00) grant_log.push_back(req_ready[1] ? 1 : 0);
        exp_v = busy && (cyc >= resp_at);
        seen_v = rsp_valid;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v && rsp_valid) begin
            check_eq("rsp_id", 32'(rsp_id), 32'(cur_id));
            check_eq("rsp_result", 32'(rsp_result), 32'(cur_exp[7:0]));
            check_eq("rsp_flags", 32'({rsp_carry, rsp_zero, rsp_overflow}), 32'(cur_exp[10:8]));
        end
        if (!busy || cyc >= resp_at) begin
            check_eq("alu_idle", 32'({alu_select, alu_in_c, alu_in_x, alu_in_y}), 32'd0);
        end else begin
            check_eq("alu_in_x", 32'(alu_in_x), (cyc == lo_cyc) ? 32'(cur_a[3:0]) : 32'(cur_a[7:4]));
            if (chk_sub_lo && cyc == lo_cyc) begin
                check_eq("sub_lo_y", 32'(alu_in_y), 32'hE);
                check_eq("sub_lo_c", 32'(alu_in_c), 32'd1);
            end
        end
        if (exp_v && rsp_rdy_drv) begin
            busy = 1'b0;
            last_id = cur_id;
        end else if (exp_rdy != 2'b00) begin
            busy    = 1'b1;
            cur_id  = w;
            cur_exp = ref_rsp(rq_op[w], rq_wide[w], rq_a[w], rq_b[w]);
            cur_a   = rq_a[w];
            lat     = (rq_wide[w] && rq_op[w] <= 3'd5) ? 3 : 2;
            resp_at = cyc + lat;
            lo_cyc  = cyc + 1;
            rq_pend[w] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy && !rq_pend[0] && !rq_pend[1]) break;
            step();
        end
        check_eq("drain", 32'({busy, rq_pend[0], rq_pend[1]}), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, 32'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
                           rsp_overflow, alu_select, alu_in_c, alu_in_x, alu_in_y}), 32'd0);
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        rq_pend[0] = 1'b0;  rq_pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rq_op[i] = 3'd0; rq_wide[i] = 1'b0; rq_a[i] = 8'h00; rq_b[i] = 8'h00;
        end
        req_valid = 2'b00; req_op0 = 3'd0; req_op1 = 3'd0; req_wide = 2'b00;
        req_a0 = 8'h00; req_b0 = 8'h00; req_a1 = 8'h00; req_b1 = 8'h00;
        rsp_ready = 1'b0; rsp_rdy_drv = 1'b1;
        busy = 1'b0; last_id = 1; cur_id = 0; cur_exp = 11'd0; cur_a = 8'h00;
        resp_at = 0; lo_cyc = 0; chk_sub_lo = 1'b0; seen_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outs("reset_outs");
        @(negedge clk);
        rst = 1'b0;

        // Narrow add, wide add, wide sub.
        set_req(0, 3'b000, 1'b0, 8'h07, 8'h01);
        run_until_idle(20);
        set_req(1, 3'b000, 1'b1, 8'h9C, 8'h75);
        run_until_idle(20);
        chk_sub_lo = 1'b1;
        set_req(0, 3'b001, 1'b1, 8'h20, 8'h21);
        run_until_idle(20);
        chk_sub_lo = 1'b0;

        // Backpressure with the other requester waiting.
        set_req(1, 3'b011, 1'b1, 8'hF3, 8'h5C);
        hold = 0;
        rsp_rdy_drv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy && !rq_pend[0] && !rq_pend[1]) break;
            rsp_rdy_drv = (hold >= 5);
            if (i == 2) set_req(0, 3'b101, 1'b0, 8'h3A, 8'h0F);
            step();
            if (seen_v) hold++;
        end
        check_eq("bp_drain", 32'({busy, rq_pend[0], rq_pend[1]}), 32'd0);
        rsp_rdy_drv = 1'b1;
        step();

        // Reset during the high pass of a wide op.
        set_req(1, 3'b000, 1'b1, 8'h5A, 8'h3B);
        for (int i = 0; i < 10; i++) begin
            if (busy && cyc == lo_cyc + 1) break;
            step();
        end
        check_eq("reach_hi", 32'(busy && cyc == lo_cyc + 1), 32'd1);
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        check_reset_outs("reset_in_hi");
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        last_id = 1;
        rq_pend[0] = 1'b0;  rq_pend[1] = 1'b0;

        // Contention with both requesters always valid.
        grant_log.delete();
        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < 2; r++)
                if (!rq_pend[r]) set_req(r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                         8'($urandom), 8'($urandom));
            step();
        end
        check_eq("grant_cnt", 32'(grant_log.size() >= 3), 32'd1);
        if (grant_log.size() >= 3) begin
            check_eq("grant_1st", 32'(grant_log[0]), 32'd0);
            check_eq("grant_2nd", 32'(grant_log[1]), 32'd1);
            check_eq("grant_3rd", 32'(grant_log[2]), 32'd0);
        end
        run_until_idle(20);

        // Random traffic with random response backpressure.
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++)
                if (!rq_pend[r] && $urandom_range(0, 3) == 0)
                    set_req(r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            8'($urandom), 8'($urandom));
            rsp_rdy_drv = ($urandom_range(0, 2) != 0);
            step();
        end
        rsp_rdy_drv = 1'b1;
        run_until_idle(30);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
